// File: rtl/mult_arb_pkg.sv
// Shared definitions for the two-requester multiplier arbiter: state encoding,
// requester indices and default parameter values.
package mult_arb_pkg;

  localparam int W_DEF        = 4;
  localparam int INIT_CYC_DEF = 2;
  localparam int TIMEOUT_DEF  = 64;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. ptr_r names the requester that wins the next tie;
// it moves to the other requester whenever a grant is taken.
module rr_arb2
  import mult_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt_vld,
  output logic gnt_idx
);

  logic ptr_r;

  // Grant selection: a lone request wins outright, a tie goes to ptr_r
  always_comb begin
    gnt_vld = en & (req0 | req1);
    if (req0 & req1) begin
      gnt_idx = ptr_r;
    end else if (req1) begin
      gnt_idx = REQ1;
    end else begin
      gnt_idx = REQ0;
    end
  end

  // Tie-break pointer, advanced on every taken grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= REQ0;
    end else if (gnt_vld) begin
      ptr_r <= ~gnt_idx;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/mult_arb.sv
// Shares one shift-add multiplier core between two requesters: arbitrates,
// sequences the core init/done handshake, and returns the product with an ack.
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int INIT_CYC = INIT_CYC_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   b0,
  output logic           ack0,
  input  logic           req1,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b1,
  output logic           ack1,
  output logic [2*W-1:0] res,
  output logic           err,
  output logic           busy,
  output logic           core_init,
  output logic [W-1:0]   core_a,
  output logic [W-1:0]   core_b,
  input  logic           core_done,
  input  logic [2*W-1:0] core_pp
);

  localparam int            TW     = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};
  localparam logic [2:0]    I_LAST = 3'(INIT_CYC - 1);

  state_t         state_r, state_s;
  logic [TW-1:0]  timer_r, timer_s;
  logic [2:0]     icnt_r, icnt_s;
  logic           win_r, win_s;
  logic [W-1:0]   core_a_r, core_a_s;
  logic [W-1:0]   core_b_r, core_b_s;
  logic [2*W-1:0] res_r, res_s;
  logic           err_r, err_s;
  logic           init_r, init_s;
  logic           ack0_r, ack0_s;
  logic           ack1_r, ack1_s;
  logic           busy_r, busy_s;
  logic           arb_en_s;
  logic           gnt_vld_s;
  logic           gnt_idx_s;

  assign arb_en_s = (state_r == IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .en      (arb_en_s),
    .req0    (req0),
    .req1    (req1),
    .gnt_vld (gnt_vld_s),
    .gnt_idx (gnt_idx_s)
  );

  // Next-state and next-output logic; outputs are computed one cycle early
  always_comb begin
    state_s  = state_r;
    timer_s  = timer_r;
    icnt_s   = icnt_r;
    win_s    = win_r;
    core_a_s = core_a_r;
    core_b_s = core_b_r;
    res_s    = res_r;
    err_s    = err_r;
    init_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (gnt_vld_s) begin
          state_s  = START;
          win_s    = gnt_idx_s;
          core_a_s = (gnt_idx_s == REQ1) ? a1 : a0;
          core_b_s = (gnt_idx_s == REQ1) ? b1 : b0;
          timer_s  = {TW{1'b0}};
          icnt_s   = 3'd0;
          init_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      // core_done is deliberately not looked at here: it may still be the
      // previous operation's flag
      START: begin
        if (icnt_r == I_LAST) begin
          state_s = WAIT;
          init_s  = 1'b0;
        end else begin
          icnt_s = icnt_r + 3'd1;
          init_s = 1'b1;
        end
      end
      WAIT: begin
        if (core_done) begin
          res_s   = core_pp;
          err_s   = 1'b0;
          state_s = RESP;
        end else if (timer_r == T_LAST) begin
          res_s   = {(2*W){1'b0}};
          err_s   = 1'b1;
          state_s = RESP;
        end else begin
          timer_s = (timer_r == T_MAX) ? timer_r : timer_r + TW'(1);
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    ack0_s = (state_s == RESP) && (win_s == REQ0);
    ack1_s = (state_s == RESP) && (win_s == REQ1);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      timer_r  <= {TW{1'b0}};
      icnt_r   <= 3'd0;
      win_r    <= REQ0;
      core_a_r <= {W{1'b0}};
      core_b_r <= {W{1'b0}};
      res_r    <= {(2*W){1'b0}};
      err_r    <= 1'b0;
      init_r   <= 1'b0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      timer_r  <= timer_s;
      icnt_r   <= icnt_s;
      win_r    <= win_s;
      core_a_r <= core_a_s;
      core_b_r <= core_b_s;
      res_r    <= res_s;
      err_r    <= err_s;
      init_r   <= init_s;
      ack0_r   <= ack0_s;
      ack1_r   <= ack1_s;
      busy_r   <= busy_s;
    end
  end

  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign res       = res_r;
  assign err       = err_r;
  assign busy      = busy_r;
  assign core_init = init_r;
  assign core_a    = core_a_r;
  assign core_b    = core_b_r;

endmodule
